// File: rtl/ram_write_arbiter_pkg.sv
// Shared definitions for the MiniAlu RAM write-port arbiter: FSM state
// encodings and the default stall-escalation threshold.
package ram_write_arbiter_pkg;

    localparam int unsigned ARB_MAX_WAIT_DEFAULT = 8;
    localparam int unsigned ARB_WAIT_W           = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PEND  = 2'd1,
        ARB_STALL = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Counts consecutive blocked cycles of the external requester; the terminal
// output marks the last blocked cycle allowed before stall escalation.
module arb_wait_counter
    import ram_write_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_enable,
    output logic                  o_terminal,
    output logic [ARB_WAIT_W-1:0] o_count
);

    localparam logic [ARB_WAIT_W-1:0] TC_VAL = ARB_WAIT_W'(MAX_WAIT - 1);

    logic [ARB_WAIT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + ARB_WAIT_W'(1);
        end
    end

    assign o_terminal = (r_count == TC_VAL);
    assign o_count    = r_count;

endmodule

// File: rtl/ram_write_arbiter.sv
// Shares the data RAM write port between core writeback (always wins) and an
// external valid/ready requester, escalating to a core stall after MAX_WAIT blocks.
module ram_write_arbiter
    import ram_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT_DEFAULT
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCoreWriteEnable,
    input  logic [ADDR_W-1:0]     iCoreAddr,
    input  logic [DATA_W-1:0]     iCoreData,
    input  logic                  iCoreStalled,
    input  logic                  iExtValid,
    input  logic [ADDR_W-1:0]     iExtAddr,
    input  logic [DATA_W-1:0]     iExtData,
    output logic                  oExtReady,
    output logic                  oStallReq,
    output logic                  oConflict,
    output logic                  oWriteEnable,
    output logic [ADDR_W-1:0]     oWriteAddr,
    output logic [DATA_W-1:0]     oWriteData,
    output logic [1:0]            oDbgState,
    output logic [ARB_WAIT_W-1:0] oDbgWait
);

    // Handshake: an external write is accepted in the cycle where iExtValid
    // and oExtReady are both 1; until then iExtAddr/iExtData must be held.
    arb_state_e r_state;
    arb_state_e w_next_state;
    logic       r_conflict;
    logic       w_grant;
    logic       w_blocked;
    logic       w_terminal;

    assign w_grant = iExtValid && !iCoreWriteEnable &&
                     ((r_state != ARB_STALL) || iCoreStalled);

    // Blocking only counts while not yet escalated; in STALL the count holds.
    assign w_blocked = iExtValid && iCoreWriteEnable && (r_state != ARB_STALL);

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .i_clk      (Clock),
        .i_rst_n    (Reset),
        .i_clear    (w_grant || !iExtValid),
        .i_enable   (w_blocked && !w_terminal),
        .o_terminal (w_terminal),
        .o_count    (oDbgWait)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ARB_IDLE;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_conflict <= r_conflict || (iCoreStalled && iCoreWriteEnable);
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_grant || !iExtValid) begin
            w_next_state = ARB_IDLE;
        end else if (w_blocked) begin
            w_next_state = w_terminal ? ARB_STALL : ARB_PEND;
        end
    end

    always_comb begin
        oWriteEnable = 1'b0;
        oWriteAddr   = '0;
        oWriteData   = '0;
        if (iCoreWriteEnable) begin
            oWriteEnable = 1'b1;
            oWriteAddr   = iCoreAddr;
            oWriteData   = iCoreData;
        end else if (w_grant) begin
            oWriteEnable = 1'b1;
            oWriteAddr   = iExtAddr;
            oWriteData   = iExtData;
        end
    end

    assign oExtReady = w_grant;
    assign oStallReq = (r_state == ARB_STALL);
    assign oConflict = r_conflict;
    assign oDbgState = r_state;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed bench for ram_write_arbiter: vector table for single-cycle
// behaviour plus hand-written escalation, withdrawal, conflict and reset cases.
module tb_ram_write_arbiter;
    import ram_write_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        core_we;
    logic [7:0]  core_addr;
    logic [15:0] core_data;
    logic        core_stalled;
    logic        ext_valid;
    logic [7:0]  ext_addr;
    logic [15:0] ext_data;
    logic        ext_ready;
    logic        stall_req;
    logic        conflict;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_wait;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ram [256];
    logic [23:0] exp_q[$];

    typedef struct {
        logic        cwe;
        logic [7:0]  caddr;
        logic [15:0] cdata;
        logic        cstl;
        logic        ev;
        logic [7:0]  eaddr;
        logic [15:0] edata;
        logic        x_rdy;
        logic        x_we;
        logic [7:0]  x_addr;
        logic [15:0] x_data;
        logic [1:0]  x_state;
        logic [7:0]  x_wait;
    } vec_t;

    vec_t vecs [9];

    ram_write_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .MAX_WAIT (8)
    ) dut (
        .Clock            (clk),
        .Reset            (rst_n),
        .iCoreWriteEnable (core_we),
        .iCoreAddr        (core_addr),
        .iCoreData        (core_data),
        .iCoreStalled     (core_stalled),
        .iExtValid        (ext_valid),
        .iExtAddr         (ext_addr),
        .iExtData         (ext_data),
        .oExtReady        (ext_ready),
        .oStallReq        (stall_req),
        .oConflict        (conflict),
        .oWriteEnable     (wr_en),
        .oWriteAddr       (wr_addr),
        .oWriteData       (wr_data),
        .oDbgState        (dbg_state),
        .oDbgWait         (dbg_wait)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural RAM fed by the arbitrated write port
    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cwe, input logic [7:0] caddr, input logic [15:0] cdata,
                         input logic cstl, input logic ev, input logic [7:0] eaddr,
                         input logic [15:0] edata);
        core_we      = cwe;
        core_addr    = caddr;
        core_data    = cdata;
        core_stalled = cstl;
        ext_valid    = ev;
        ext_addr     = eaddr;
        ext_data     = edata;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        rst_n = 1'b0;

        // table: {inputs, comb outputs this cycle, state/wait after the edge}
        vecs[0] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h10, 16'hBEEF,
                    1'b1, 1'b1, 8'h10, 16'hBEEF, ARB_IDLE, 8'd0};
        vecs[1] = '{1'b1, 8'h02, 16'h0005, 1'b0, 1'b1, 8'h02, 16'h1111,
                    1'b0, 1'b1, 8'h02, 16'h0005, ARB_PEND, 8'd1};
        vecs[2] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h02, 16'h1111,
                    1'b1, 1'b1, 8'h02, 16'h1111, ARB_IDLE, 8'd0};
        vecs[3] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000,
                    1'b0, 1'b0, 8'h00, 16'h0000, ARB_IDLE, 8'd0};
        vecs[4] = '{1'b1, 8'h33, 16'hAAAA, 1'b0, 1'b0, 8'h00, 16'h0000,
                    1'b0, 1'b1, 8'h33, 16'hAAAA, ARB_IDLE, 8'd0};
        vecs[5] = '{1'b1, 8'h40, 16'h1234, 1'b0, 1'b1, 8'h41, 16'h5678,
                    1'b0, 1'b1, 8'h40, 16'h1234, ARB_PEND, 8'd1};
        vecs[6] = '{1'b1, 8'h42, 16'h2345, 1'b0, 1'b1, 8'h41, 16'h5678,
                    1'b0, 1'b1, 8'h42, 16'h2345, ARB_PEND, 8'd2};
        vecs[7] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h41, 16'h5678,
                    1'b0, 1'b0, 8'h00, 16'h0000, ARB_IDLE, 8'd0};
        vecs[8] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000,
                    1'b0, 1'b0, 8'h00, 16'h0000, ARB_IDLE, 8'd0};

        exp_q.push_back({8'h10, 16'hBEEF});
        exp_q.push_back({8'h02, 16'h1111});
        exp_q.push_back({8'h33, 16'hAAAA});
        exp_q.push_back({8'h40, 16'h1234});
        exp_q.push_back({8'h42, 16'h2345});

        #1;
        chk("reset_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("reset_wait", 32'(dbg_wait), 32'd0);
        chk("reset_stall", 32'(stall_req), 32'd0);
        chk("reset_conflict", 32'(conflict), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].cwe, vecs[i].caddr, vecs[i].cdata, vecs[i].cstl,
                  vecs[i].ev, vecs[i].eaddr, vecs[i].edata);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(ext_ready), 32'(vecs[i].x_rdy));
            chk($sformatf("v%0d_we", i), 32'(wr_en), 32'(vecs[i].x_we));
            chk($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(vecs[i].x_addr));
            chk($sformatf("v%0d_data", i), 32'(wr_data), 32'(vecs[i].x_data));
            if (i == 1) begin
                // core write landed first at the shared address
                edge_settle();
                chk("prio_ram_core", 32'(ram[8'h02]), 32'h0005);
            end else begin
                edge_settle();
            end
            chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].x_state));
            chk($sformatf("v%0d_wait", i), 32'(dbg_wait), 32'(vecs[i].x_wait));
            chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'd0);
            chk($sformatf("v%0d_conflict", i), 32'(conflict), 32'd0);
            @(negedge clk);
        end

        // escalation: 8 consecutive blocked cycles raise the stall request
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(8'h80 + i), 16'(i), 1'b0, 1'b1, 8'h55, 16'hCAFE);
            #1;
            chk($sformatf("esc%0d_ready", i), 32'(ext_ready), 32'd0);
            edge_settle();
            chk($sformatf("esc%0d_stall", i), 32'(stall_req), 32'(i == 8));
            @(negedge clk);
        end
        chk("esc_state", 32'(dbg_state), 32'(ARB_STALL));
        chk("esc_wait", 32'(dbg_wait), 32'd7);
        // still blocked in STALL: hold state and count
        drive(1'b1, 8'h90, 16'h0090, 1'b0, 1'b1, 8'h55, 16'hCAFE);
        #1;
        chk("stall_blocked_ready", 32'(ext_ready), 32'd0);
        edge_settle();
        chk("stall_hold_state", 32'(dbg_state), 32'(ARB_STALL));
        chk("stall_hold_wait", 32'(dbg_wait), 32'd7);
        @(negedge clk);
        // core idle but not yet stalled: no grant in STALL
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h55, 16'hCAFE);
        #1;
        chk("stall_nostl_ready", 32'(ext_ready), 32'd0);
        chk("stall_nostl_we", 32'(wr_en), 32'd0);
        edge_settle();
        chk("stall_nostl_stall", 32'(stall_req), 32'd1);
        @(negedge clk);
        drive(1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h55, 16'hCAFE);
        #1;
        chk("stall_grant_ready", 32'(ext_ready), 32'd1);
        chk("stall_grant_addr", 32'(wr_addr), 32'h55);
        chk("stall_grant_data", 32'(wr_data), 32'hCAFE);
        edge_settle();
        chk("stall_release", 32'(stall_req), 32'd0);
        chk("stall_release_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("stall_ram", 32'(ram[8'h55]), 32'hCAFE);
        @(negedge clk);

        // withdrawal after 3 blocked cycles, then a fresh request needs the full 8
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'hA0, 16'h0A0A, 1'b0, 1'b1, 8'h66, 16'h6666);
            edge_settle();
            @(negedge clk);
        end
        chk("wd_pend_state", 32'(dbg_state), 32'(ARB_PEND));
        chk("wd_pend_wait", 32'(dbg_wait), 32'd3);
        drive(1'b1, 8'hA0, 16'h0A0A, 1'b0, 1'b0, 8'h66, 16'h6666);
        edge_settle();
        chk("wd_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("wd_wait", 32'(dbg_wait), 32'd0);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'hB0, 16'h0B0B, 1'b0, 1'b1, 8'h77, 16'h7777);
            edge_settle();
            chk($sformatf("fresh%0d_stall", i), 32'(stall_req), 32'(i == 8));
            @(negedge clk);
        end

        // conflict in STALL: core still owns the port, flag becomes sticky
        drive(1'b1, 8'h60, 16'h7070, 1'b1, 1'b1, 8'h77, 16'h7777);
        #1;
        chk("conf_ready", 32'(ext_ready), 32'd0);
        chk("conf_addr", 32'(wr_addr), 32'h60);
        chk("conf_data", 32'(wr_data), 32'h7070);
        edge_settle();
        chk("conf_set", 32'(conflict), 32'd1);
        chk("conf_ram", 32'(ram[8'h60]), 32'h7070);
        chk("conf_state", 32'(dbg_state), 32'(ARB_STALL));
        @(negedge clk);
        drive(1'b1, 8'h61, 16'h0001, 1'b0, 1'b1, 8'h77, 16'h7777);
        edge_settle();
        edge_settle();
        chk("conf_sticky", 32'(conflict), 32'd1);
        chk("pre_rst_stall", 32'(stall_req), 32'd1);

        // asynchronous reset in the middle of a cycle while in STALL
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_conflict", 32'(conflict), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h88, 16'h8888);
        #1;
        chk("post_rst_ready", 32'(ext_ready), 32'd1);
        edge_settle();
        chk("post_rst_ram", 32'(ram[8'h88]), 32'h8888);
        chk("post_rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        @(negedge clk);
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

        // untouched-since table entries must still hold their values
        while (exp_q.size() > 0) begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk($sformatf("ram_%02h", e[23:16]), 32'(ram[e[23:16]]), 32'(e[15:0]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
